lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side companion of the 8-bit XNOR LFSR generator. Consumes the serial
//  bit stream the generator produces (newly inserted bit per step), self-syncs
//  to it, then flywheels a local LFSR to flag bit errors and count them.
//  Sits at the sink end of PRBS links and self-test paths.
// PARAMETERS
//  LOCK_CNT   16  consecutive correct predictions in HUNT required to lock
//  ERR_LIMIT  4   errors within one window that force loss of lock
//  WIN_LEN    64  window length in valid bits for ERR_LIMIT accounting
//  CNT_W      16  width of err_count
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  bit_in     in   1      received stream bit, sampled when bit_valid=1
//  bit_valid  in   1      qualifies bit_in; 0 = stall, all state held
//  clear_cnt  in   1      synchronous clear of err_count
//  locked     out  1      1 while in LOCKED
//  err_pulse  out  1      1-cycle pulse per mismatched bit in LOCKED
//  err_count  out  CNT_W  saturating total error count
//  stuck_ones out  1      1 while HUNT window is full and equals 8'hFF
//  state      out  2      0=HUNT, 2=LOCKED (1,3 unused)
// BEHAVIOUR
//  Generator rule: next = ~(s[7]^s[5]^s[4]^s[3]); s <= {s[6:0], next}; stream bit = next.
//  Prediction from 8-bit register r: pred = ~(r[7]^r[5]^r[4]^r[3]).
//  Reset (sync): state=HUNT, r=0, fill=0, match=0, win_cnt=0, win_err=0,
//    locked=0, err_pulse=0, err_count=0, stuck_ones=0.
//  All outputs registered; response to a bit sampled at edge N visible after edge N.
//  bit_valid=0: no state change; err_pulse=0.
//  HUNT: each valid bit: r <= {r[6:0], bit_in} (self-sync from received data).
//    fill counts 0..8, saturates at 8; no comparison while fill<8.
//    fill==8: compare bit_in vs pred(r): match -> match+1, mismatch -> match=0.
//    r==8'hFF (fill==8): stuck_ones=1, match held 0 (all-ones lockup never locks).
//    match reaching LOCK_CNT -> state=LOCKED, locked=1 next cycle;
//      win_cnt=0, win_err=0 on entry. No err_pulse/err_count activity in HUNT.
//  LOCKED: each valid bit: r <= {r[6:0], pred} (flywheel; received errors not loaded).
//    r never becomes 8'hFF from a non-FF state (FF is the only fixed point).
//    bit_in != pred -> err_pulse=1, err_count+1 (saturate at all-ones), win_err+1.
//    win_cnt counts valid bits 0..WIN_LEN-1; at wrap win_cnt=0 and win_err=0.
//    win_err reaching ERR_LIMIT -> state=HUNT, locked=0, fill=0, match=0; err_pulse
//      for that bit still asserted; loss has priority over window wrap same bit.
//  clear_cnt: err_count=0; same cycle as counted error -> err_count=1 (error not lost).
//    clear_cnt does not affect state, window counters or r.
//  reset mid-LOCKED or mid-HUNT: full return to reset values next edge; overrides all.
// TESTING
//  T1 lock: gen seed 8'h01, 24 continuous valid bits -> locked=1 after 24th bit, err_count=0.
//  T2 single flip: locked, invert 1 bit -> one err_pulse, err_count=1, locked stays 1,
//     next 100 bits zero errors (flywheel, no error propagation).
//  T3 burst: 4 flips within 64 bits -> locked=0 after 4th flip, 4 err_pulses,
//     err_count=4; clean stream then relocks after 24 bits.
//  T4 stuck: constant bit_in=1 for 200 bits -> stuck_ones=1 from 8th bit, never locks.
//  T5 stalls: T1 with random bit_valid gaps -> identical locked/err results per valid bit.
//  T6 misc: clear_cnt coincident with error -> err_count=1; reset while LOCKED ->
//     all outputs 0 next cycle; 3 flips per 64-bit window forever -> stays locked.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// Purpose: stream and status bundle between a PRBS bit source and lfsr_checker.
// Latency: none; this is wiring only.
// Backpressure: none; bit_valid qualifies each bit and the sink always accepts it.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic             stuck_ones;
    logic [1:0]       state;

    // The source drives the stream and the clear request, and observes status.
    modport master (
        output bit_in, bit_valid, clear_cnt,
        input  locked, err_pulse, err_count, stuck_ones, state
    );

    // The checker consumes the stream and the clear request, and drives status.
    modport slave (
        input  bit_in, bit_valid, clear_cnt,
        output locked, err_pulse, err_count, stuck_ones, state
    );
endinterface

// File: rtl/lfsr_checker.sv
// Purpose: self-syncing receive checker for the 8-bit XNOR PRBS; hunts, locks, flywheels, counts bit errors.
// Latency: every output is registered; a bit sampled at edge N is reflected after edge N.
// Backpressure: none; bit_valid=0 stalls the checker and holds all of its state.
module lfsr_checker #(
    parameter int LOCK_CNT  = 16,
    parameter int ERR_LIMIT = 4,
    parameter int WIN_LEN   = 64,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(ERR_LIMIT);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);

    logic [1:0]         state_q, state_d;
    logic [7:0]         r_q, r_d;
    logic [3:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               stuck_ones_q, stuck_ones_d;

    logic               pred;
    logic               mismatch;
    logic [MATCH_W-1:0] match_nxt;
    logic [WERR_W-1:0]  win_err_nxt;

    // Next-state logic: hunt by loading received bits, then flywheel the local LFSR once locked.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        pred        = ~(r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]);
        mismatch    = 1'b0;
        match_nxt   = match_q;
        win_err_nxt = win_err_q;

        if (bus.bit_valid) begin
            if (state_q == ST_HUNT) begin
                r_d = {r_q[6:0], bus.bit_in};
                if (fill_q != 4'd8) begin
                    fill_d = fill_q + 4'd1;
                end else begin
                    // All-ones is the lockup state and predicts itself; it must never lock.
                    if (r_q == 8'hFF || bus.bit_in != pred) begin
                        match_nxt = '0;
                    end else begin
                        match_nxt = match_q + 1'b1;
                    end
                    match_d = match_nxt;
                    if (match_nxt == MATCH_LOCK) begin
                        state_d   = ST_LOCKED;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
            end else begin
                // Flywheel: the received bit is only compared, never loaded.
                r_d         = {r_q[6:0], pred};
                mismatch    = (bus.bit_in != pred);
                win_err_nxt = win_err_q + WERR_W'(mismatch);
                if (win_err_nxt == WERR_LOSS) begin
                    // Loss of lock wins over a window wrap on the same bit.
                    state_d   = ST_HUNT;
                    fill_d    = '0;
                    match_d   = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    win_err_d = win_err_nxt;
                end
            end
        end

        err_pulse_d = mismatch;

        // A clear that coincides with a counted error keeps that error.
        if (bus.clear_cnt) begin
            err_count_d = CNT_W'(mismatch);
        end else if (mismatch && err_count_q != {CNT_W{1'b1}}) begin
            err_count_d = err_count_q + 1'b1;
        end else begin
            err_count_d = err_count_q;
        end

        locked_d     = (state_d == ST_LOCKED);
        stuck_ones_d = (state_d == ST_HUNT) && (fill_d == 4'd8) && (r_d == 8'hFF);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            r_q          <= '0;
            fill_q       <= '0;
            match_q      <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            stuck_ones_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            fill_q       <= fill_d;
            match_q      <= match_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            stuck_ones_q <= stuck_ones_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.stuck_ones = stuck_ones_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Purpose: directed self-checking bench for lfsr_checker (lock, flips, bursts, stuck, stalls, misc).
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: bit_valid gaps are injected to exercise stalls.
module tb_lfsr_checker;
    logic clk;
    logic reset;
    logic [7:0] g;
    int checks;
    int passed;

    lfsr_checker_if #(.CNT_W(16)) bus ();

    lfsr_checker dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are stable when it returns.
    task automatic tick(input logic b, input logic v, input logic clr);
        bus.bit_in    = b;
        bus.bit_valid = v;
        bus.clear_cnt = clr;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.clear_cnt = 1'b0;
    endtask

    // Reference generator: XNOR of taps 7,5,4,3, new bit shifted in at the bottom.
    task automatic gen_next(output logic b);
        b = ~(g[7] ^ g[5] ^ g[4] ^ g[3]);
        g = {g[6:0], b};
    endtask

    task automatic send_gen(input logic flip);
        logic b;
        gen_next(b);
        tick(b ^ flip, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic do_lock();
        do_reset();
        g = 8'h01;
        repeat (24) send_gen(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", bus.locked); else passed++;
        checks++;
        if (bus.state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.state); else passed++;
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.stuck_ones !== 1'b0)
            $display("FAIL reset_flags got pulse=%b stuck=%b exp=0,0", bus.err_pulse, bus.stuck_ones);
        else passed++;
        checks++;
        if (bus.err_count !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", bus.err_count); else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        g = 8'h01;
        repeat (23) send_gen(1'b0);
        checks++;
        if (bus.locked !== 1'b0) $display("FAIL lock_early got=%b exp=0 after 23 bits", bus.locked); else passed++;
        send_gen(1'b0);
        checks++;
        if (bus.locked !== 1'b1) $display("FAIL lock_24 got=%b exp=1", bus.locked); else passed++;
        checks++;
        if (bus.state !== 2'd2) $display("FAIL lock_state got=%0d exp=2", bus.state); else passed++;
        checks++;
        if (bus.err_count !== 16'd0) $display("FAIL lock_err_count got=%0d exp=0", bus.err_count); else passed++;
    endtask

    task automatic test_single_flip();
        int pulses;
        do_lock();
        send_gen(1'b1);
        checks++;
        if (bus.err_pulse !== 1'b1) $display("FAIL flip_pulse got=%b exp=1", bus.err_pulse); else passed++;
        checks++;
        if (bus.err_count !== 16'd1) $display("FAIL flip_count got=%0d exp=1", bus.err_count); else passed++;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            send_gen(1'b0);
            if (bus.err_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL flip_propagation got=%0d pulses exp=0", pulses); else passed++;
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd1)
            $display("FAIL flip_after got locked=%b count=%0d exp=1,1", bus.locked, bus.err_count);
        else passed++;
    endtask

    task automatic test_burst();
        int pulses;
        logic lk3;
        do_lock();
        pulses = 0;
        lk3 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_gen((i % 5) == 0);
            if (bus.err_pulse === 1'b1) pulses++;
            if (i == 10) lk3 = bus.locked;
        end
        checks++;
        if (lk3 !== 1'b1) $display("FAIL burst_3rd_locked got=%b exp=1", lk3); else passed++;
        checks++;
        if (bus.locked !== 1'b0 || bus.state !== 2'd0)
            $display("FAIL burst_loss got locked=%b state=%0d exp=0,0", bus.locked, bus.state);
        else passed++;
        checks++;
        if (pulses !== 4 || bus.err_count !== 16'd4)
            $display("FAIL burst_count got pulses=%0d count=%0d exp=4,4", pulses, bus.err_count);
        else passed++;
        repeat (23) send_gen(1'b0);
        checks++;
        if (bus.locked !== 1'b0) $display("FAIL relock_early got=%b exp=0", bus.locked); else passed++;
        send_gen(1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd4)
            $display("FAIL relock got locked=%b count=%0d exp=1,4", bus.locked, bus.err_count);
        else passed++;
    endtask

    task automatic test_stuck();
        int bad_stuck;
        int ever_locked;
        do_reset();
        repeat (7) tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.stuck_ones !== 1'b0) $display("FAIL stuck_early got=%b exp=0", bus.stuck_ones); else passed++;
        bad_stuck = 0;
        ever_locked = 0;
        for (int i = 7; i < 200; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (bus.stuck_ones !== 1'b1) bad_stuck++;
            if (bus.locked !== 1'b0) ever_locked++;
        end
        checks++;
        if (bad_stuck !== 0) $display("FAIL stuck_flag got=%0d low cycles exp=0", bad_stuck); else passed++;
        checks++;
        if (ever_locked !== 0) $display("FAIL stuck_locked got=%0d locked cycles exp=0", ever_locked); else passed++;
    endtask

    task automatic test_stalls();
        int stray;
        do_reset();
        g = 8'h01;
        stray = 0;
        for (int k = 0; k < 24; k++) begin
            for (int s = 0; s < (k % 3); s++) begin
                tick(1'($urandom_range(1, 0)), 1'b0, 1'b0);
                if (bus.err_pulse !== 1'b0) stray++;
            end
            send_gen(1'b0);
            if (k == 22) begin
                checks++;
                if (bus.locked !== 1'b0) $display("FAIL stall_early got=%b exp=0", bus.locked); else passed++;
            end
        end
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd0)
            $display("FAIL stall_lock got locked=%b count=%0d exp=1,0", bus.locked, bus.err_count);
        else passed++;
        send_gen(1'b1);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.err_count !== 16'd1 || bus.state !== 2'd2)
            $display("FAIL stall_hold got pulse=%b count=%0d state=%0d exp=0,1,2",
                     bus.err_pulse, bus.err_count, bus.state);
        else passed++;
        checks++;
        if (stray !== 0) $display("FAIL stall_pulse got=%0d exp=0", stray); else passed++;
    endtask

    task automatic test_misc();
        logic b;
        int drops;
        int bad_pulse;
        // Clear coincident with an error keeps that error.
        do_lock();
        gen_next(b);
        tick(~b, 1'b1, 1'b1);
        checks++;
        if (bus.err_count !== 16'd1) $display("FAIL clear_coincident got=%0d exp=1", bus.err_count); else passed++;
        send_gen(1'b1);
        checks++;
        if (bus.err_count !== 16'd2) $display("FAIL clear_then_err got=%0d exp=2", bus.err_count); else passed++;
        gen_next(b);
        tick(b, 1'b1, 1'b1);
        checks++;
        if (bus.err_count !== 16'd0 || bus.locked !== 1'b1)
            $display("FAIL clear_plain got count=%0d locked=%b exp=0,1", bus.err_count, bus.locked);
        else passed++;

        // Reset while locked returns everything to idle.
        do_lock();
        send_gen(1'b1);
        reset = 1'b1;
        gen_next(b);
        tick(~b, 1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if (bus.locked !== 1'b0 || bus.state !== 2'd0 || bus.err_pulse !== 1'b0 ||
            bus.err_count !== 16'd0 || bus.stuck_ones !== 1'b0)
            $display("FAIL reset_locked got locked=%b state=%0d pulse=%b count=%0d stuck=%b exp all 0",
                     bus.locked, bus.state, bus.err_pulse, bus.err_count, bus.stuck_ones);
        else passed++;

        // Three errors per window, clustered across window boundaries, never lose lock.
        do_lock();
        drops = 0;
        bad_pulse = 0;
        for (int i = 0; i < 320; i++) begin
            logic f;
            f = ((i % 64) == 0) || ((i % 64) == 62) || ((i % 64) == 63);
            send_gen(f);
            if (bus.locked !== 1'b1) drops++;
            if (bus.err_pulse !== f) bad_pulse++;
        end
        checks++;
        if (drops !== 0) $display("FAIL window3_drops got=%0d exp=0", drops); else passed++;
        checks++;
        if (bad_pulse !== 0 || bus.err_count !== 16'd15)
            $display("FAIL window3_errors got badpulse=%0d count=%0d exp=0,15", bad_pulse, bus.err_count);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        g = 8'h01;
        reset = 1'b1;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clear_cnt = 1'b0;
        test_reset();
        test_lock();
        test_single_flip();
        test_burst();
        test_stuck();
        test_stalls();
        test_misc();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
